// File: rtl/dct_pkg.sv
// Shared types for the binDCT row/column passes and the transpose buffer.
// Holds block size, coefficient width, vector and index types, small helpers.
package dct_pkg;

  localparam int DCT_N  = 8;
  localparam int COEF_W = 32;
  localparam int IDX_W  = $clog2(DCT_N);

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t vec_t [0:DCT_N-1];
  typedef logic [IDX_W-1:0] idx_t;

  function automatic logic idx_last(
    input idx_t i
  );
    return i == idx_t'(DCT_N - 1);
  endfunction

  function automatic idx_t idx_next(
    input idx_t i
  );
    return i + idx_t'(1);
  endfunction

endpackage

// File: rtl/dct_transpose_buf_if.sv
// Row-in / column-out stream bundle of the transpose buffer.
// master: producer+consumer side; slave: the buffer.
interface dct_transpose_buf_if #(
  parameter int WIDTH = dct_pkg::COEF_W
) ();
  import dct_pkg::*;

  logic                    valid_in;
  logic                    ready_in;
  logic signed [WIDTH-1:0] din [0:DCT_N-1];
  logic                    valid_out;
  logic                    ready_out;
  logic signed [WIDTH-1:0] dout [0:DCT_N-1];
  logic                    last_out;

  modport master (
    output valid_in,
    output din,
    output ready_out,
    input  ready_in,
    input  valid_out,
    input  dout,
    input  last_out
  );

  modport slave (
    input  valid_in,
    input  din,
    input  ready_out,
    output ready_in,
    output valid_out,
    output dout,
    output last_out
  );

endinterface

// File: rtl/dct_tp_bank.sv
// One 8x8 coefficient bank: row-wide write port, combinational column read.
// Ports: clk, we/row/wdata (write a row), col -> rdata (read a column).
module dct_tp_bank
  import dct_pkg::*;
#(
  parameter int WIDTH = COEF_W
) (
  input  logic                    clk,
  input  logic                    we,
  input  idx_t                    row,
  input  logic signed [WIDTH-1:0] wdata [0:DCT_N-1],
  input  idx_t                    col,
  output logic signed [WIDTH-1:0] rdata [0:DCT_N-1]
);

  logic signed [WIDTH-1:0] mem [0:DCT_N-1][0:DCT_N-1];

  // Contents survive reset; only the flags in the top decide validity.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < DCT_N; c++) begin
        mem[row][c] <= wdata[c];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < DCT_N; r++) begin
      rdata[r] = mem[r][col];
    end
  end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between binDCT row and column passes.
// Ports: clk, rst (sync, active-high), io (rows in, columns out, last_out).
module dct_transpose_buf
  import dct_pkg::*;
#(
  parameter int WIDTH = COEF_W
) (
  input  logic                clk,
  input  logic                rst,
  dct_transpose_buf_if.slave  io
);

  typedef logic signed [WIDTH-1:0] word_t;

  logic [1:0] full;
  logic       wr_bank;
  logic       rd_bank;
  idx_t       wr_row;
  idx_t       rd_col;

  logic       wr_fire;
  logic       rd_fire;
  logic       wr_done;
  logic       rd_done;
  logic [1:0] bank_we;
  logic [1:0] set_full;
  logic [1:0] clr_full;

  word_t      rd_vec0 [0:DCT_N-1];
  word_t      rd_vec1 [0:DCT_N-1];
  word_t      dout_mux [0:DCT_N-1];

  assign io.ready_in  = !full[wr_bank];
  assign io.valid_out = full[rd_bank];
  assign io.last_out  = io.valid_out
                     && idx_last(rd_col);

  assign wr_fire = io.valid_in && io.ready_in;
  assign rd_fire = io.valid_out && io.ready_out;
  assign wr_done = wr_fire && idx_last(wr_row);
  assign rd_done = rd_fire && idx_last(rd_col);

  assign bank_we[0] = wr_fire && !wr_bank;
  assign bank_we[1] = wr_fire && wr_bank;

  // A completing write and a completing read always
  // target different banks, so set and clear never collide.
  always_comb begin
    set_full = 2'b00;
    clr_full = 2'b00;
    if (wr_done) begin
      set_full[wr_bank] = 1'b1;
    end
    if (rd_done) begin
      clr_full[rd_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      wr_row  <= '0;
      rd_bank <= 1'b0;
      rd_col  <= '0;
    end else begin
      full <= (full & ~clr_full) | set_full;
      if (wr_fire) begin
        wr_row <= idx_next(wr_row);
        if (wr_done) begin
          wr_bank <= !wr_bank;
        end
      end
      if (rd_fire) begin
        rd_col <= idx_next(rd_col);
        if (rd_done) begin
          rd_bank <= !rd_bank;
        end
      end
    end
  end

  dct_tp_bank #(
    .WIDTH (WIDTH)
  ) u_bank0 (
    .clk   (clk),
    .we    (bank_we[0]),
    .row   (wr_row),
    .wdata (io.din),
    .col   (rd_col),
    .rdata (rd_vec0)
  );

  dct_tp_bank #(
    .WIDTH (WIDTH)
  ) u_bank1 (
    .clk   (clk),
    .we    (bank_we[1]),
    .row   (wr_row),
    .wdata (io.din),
    .col   (rd_col),
    .rdata (rd_vec1)
  );

  // Idle output is forced to zero so stale bank data never leaks.
  always_comb begin
    for (int r = 0; r < DCT_N; r++) begin
      dout_mux[r] = '0;
      if (io.valid_out) begin
        dout_mux[r] = rd_bank ? rd_vec1[r]
                              : rd_vec0[r];
      end
    end
  end

  assign io.dout = dout_mux;

endmodule
